// File: rtl/tickgen_pkg.sv
// -----------------------------------------------------------------------------
// tickgen_pkg
// Shared constants and helpers for the multi-rate tick generator.
//   TICKGEN_MIN_DIV  : smallest base divisor the prescaler accepts. A runtime
//                      divisor below this is raised to it.
//   tg_cnt_width()   : bits needed to hold 0..max_val (never less than 1).
//   tg_elapsed_max() : all-ones saturation value of a w-bit elapsed counter
//                      (w up to 64).
// No ports: this is a package. Import it with  import tickgen_pkg::*;
// -----------------------------------------------------------------------------
package tickgen_pkg;

  localparam int unsigned TICKGEN_MIN_DIV = 2;

  // Bits needed to represent every value in 0..max_val.
  function automatic int unsigned tg_cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Saturation ceiling of a w-bit counter, returned as a 64-bit value.
  // Callers cast the result down to their own width.
  function automatic logic [63:0] tg_elapsed_max(input int unsigned w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/tick_stage.sv
// -----------------------------------------------------------------------------
// tick_stage
// One cascaded modulo-STAGE_DIV counter. It advances only when the stage
// below it wraps, and it reports its own wrap combinationally so that the
// next stage sees it in the same cycle. Because of this, every coincident
// tick in the chain rises in the same cycle.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (counter -> 0)
//   clr    in   synchronous clear; takes priority over adv
//   adv    in   advance strobe (wrap of the previous stage)
//   wrap   out  adv & (count == STAGE_DIV-1), combinational
// -----------------------------------------------------------------------------
module tick_stage
  import tickgen_pkg::*;
#(
  parameter int unsigned STAGE_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic adv,
  output logic wrap
);

  localparam int unsigned    SW   = tg_cnt_width(STAGE_DIV - 1);
  localparam logic [SW-1:0]  TERM = SW'(STAGE_DIV - 1);

  logic [SW-1:0] cnt_q;
  logic [SW-1:0] cnt_d;

  assign wrap = adv & (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else if (adv) begin
      cnt_d = cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_generator.sv
// -----------------------------------------------------------------------------
// tick_generator
// A multi-rate tick source for the reaction-timer datapath.
//  - The base prescaler divides clk by the active divisor. Its wrap (w0)
//    produces tick[0].
//  - NUM_STAGES-1 tick_stage instances divide each wrap by STAGE_DIV again,
//    which gives tick[k] every BASE_DIV*STAGE_DIV^k enabled cycles.
//  - The elapsed counter counts base wraps and saturates at all-ones.
// Optional feature, macro TICKGEN_RUNTIME_DIV_EN:
//  - When the macro is defined, the base divisor can be reloaded at runtime
//    through div_wr/div_val.
//  - When it is undefined, the divisor is the constant BASE_DIV, and the
//    div ports and registers do not exist.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   count enable; low freezes every counter (no phase loss)
//   clr      in   synchronous clear of counters/ticks/elapsed; beats en
//   div_wr   in   (macro only) load strobe for a new base divisor
//   div_val  in   (macro only) new base divisor, CW bits
//   tick     out  NUM_STAGES one-cycle pulses, registered
//   elapsed  out  saturating count of base ticks since clr/reset
// Load protocol: div_wr is a single-cycle strobe and has no handshake.
//   - Every div_wr is accepted. The value is clamped up to TICKGEN_MIN_DIV
//     and stored as pending. A later write overwrites an earlier one.
//   - The pending value becomes the active divisor on the next base wrap or
//     clr, so the period in flight always completes at the old divisor.
//   - A write in the same cycle as a wrap or clr applies directly to the
//     period that starts next.
// -----------------------------------------------------------------------------
module tick_generator
  import tickgen_pkg::*;
#(
  parameter  int unsigned BASE_DIV   = 100000,  // >= 2
  parameter  int unsigned NUM_STAGES = 3,       // >= 1
  parameter  int unsigned STAGE_DIV  = 10,      // >= 2
  parameter  int unsigned ELAPSED_W  = 16,      // <= 64
  localparam int unsigned CW         = $clog2(BASE_DIV + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
`ifdef TICKGEN_RUNTIME_DIV_EN
  input  logic                  div_wr,
  input  logic [CW-1:0]         div_val,
`endif
  output logic [NUM_STAGES-1:0] tick,
  output logic [ELAPSED_W-1:0]  elapsed
);

  localparam logic [CW-1:0]        BASE_DIV_C  = CW'(BASE_DIV);
  localparam logic [ELAPSED_W-1:0] ELAPSED_MAX = ELAPSED_W'(tg_elapsed_max(ELAPSED_W));

  logic [CW-1:0]         c0_q;
  logic [CW-1:0]         c0_d;
  logic [CW-1:0]         div_act;
  logic                  w0;
  logic [NUM_STAGES-1:0] wrap_vec;
  logic [NUM_STAGES-1:0] tick_q;
  logic [NUM_STAGES-1:0] tick_d;
  logic [ELAPSED_W-1:0]  elapsed_q;
  logic [ELAPSED_W-1:0]  elapsed_d;

  // ---------------------------------------------------------------------------
  // Divisor selection
  // ---------------------------------------------------------------------------
`ifdef TICKGEN_RUNTIME_DIV_EN
  localparam logic [CW-1:0] MIN_DIV_C = CW'(TICKGEN_MIN_DIV);

  logic [CW-1:0] div_act_q;
  logic [CW-1:0] div_act_d;
  logic [CW-1:0] div_pend_q;
  logic [CW-1:0] div_pend_d;
  logic          pend_vld_q;
  logic          pend_vld_d;
  logic [CW-1:0] div_wr_clamped;

  assign div_wr_clamped = (div_val < MIN_DIV_C) ? MIN_DIV_C : div_val;
  assign div_act        = div_act_q;

  always_comb begin
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_vld_d = pend_vld_q;
    if (w0 || clr) begin
      // Period boundary. A write arriving now wins over the older pending
      // value, and the pending slot is always emptied here.
      if (div_wr) begin
        div_act_d = div_wr_clamped;
      end else if (pend_vld_q) begin
        div_act_d = div_pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (div_wr) begin
      div_pend_d = div_wr_clamped;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_act_q  <= BASE_DIV_C;
      div_pend_q <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end
`else
  assign div_act = BASE_DIV_C;
`endif

  // ---------------------------------------------------------------------------
  // Base prescaler: c0 runs over 0..div_act-1.
  // ---------------------------------------------------------------------------
  assign w0 = en & (c0_q == (div_act - CW'(1)));

  always_comb begin
    c0_d = c0_q;
    if (clr) begin
      c0_d = '0;
    end else if (w0) begin
      c0_d = '0;
    end else if (en) begin
      c0_d = c0_q + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Cascaded stages. wrap_vec[k] is the combinational wrap of stage k, and
  // stage 0 is the prescaler itself.
  // ---------------------------------------------------------------------------
  assign wrap_vec[0] = w0;

  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
    tick_stage #(
      .STAGE_DIV (STAGE_DIV)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .adv   (wrap_vec[k-1]),
      .wrap  (wrap_vec[k])
    );
  end

  // clr discards any wrap that happens in the same cycle.
  assign tick_d = clr ? '0 : wrap_vec;

  // ---------------------------------------------------------------------------
  // Elapsed base-tick counter. It saturates instead of wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    elapsed_d = elapsed_q;
    if (clr) begin
      elapsed_d = '0;
    end else if (w0 && (elapsed_q != ELAPSED_MAX)) begin
      elapsed_d = elapsed_q + ELAPSED_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0_q      <= '0;
      tick_q    <= '0;
      elapsed_q <= '0;
    end else begin
      c0_q      <= c0_d;
      tick_q    <= tick_d;
      elapsed_q <= elapsed_d;
    end
  end

  assign tick    = tick_q;
  assign elapsed = elapsed_q;

endmodule

// File: tb/tb_tick_generator.sv
// -----------------------------------------------------------------------------
// tb_tick_generator
// Self-checking bench for tick_generator with BASE_DIV=5, NUM_STAGES=3,
// STAGE_DIV=3, ELAPSED_W=4.
// The reference model tracks three things:
//   - the phase inside the current base period,
//   - the number of base ticks since clr/reset,
//   - the active divisor.
// From these it derives:
//   - tick[k]: a base wrap whose running count is a multiple of STAGE_DIV^k,
//   - elapsed: min(count, 2^ELAPSED_W-1).
// Directed scenarios pin the model with hand-computed cycle numbers, and a
// random phase exercises en/clr (and div_wr when TICKGEN_RUNTIME_DIV_EN is
// defined).
// -----------------------------------------------------------------------------
module tb_tick_generator;

  localparam int BASE_DIV   = 5;
  localparam int NUM_STAGES = 3;
  localparam int STAGE_DIV  = 3;
  localparam int ELAPSED_W  = 4;
  localparam int CW         = $clog2(BASE_DIV + 1);
  localparam int EL_MAX     = (1 << ELAPSED_W) - 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic                  clr;
  logic                  div_wr;
  logic [CW-1:0]         div_val;
  logic [NUM_STAGES-1:0] tick;
  logic [ELAPSED_W-1:0]  elapsed;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  tick_generator #(
    .BASE_DIV   (BASE_DIV),
    .NUM_STAGES (NUM_STAGES),
    .STAGE_DIV  (STAGE_DIV),
    .ELAPSED_W  (ELAPSED_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
`ifdef TICKGEN_RUNTIME_DIV_EN
    .div_wr  (div_wr),
    .div_val (div_val),
`endif
    .tick    (tick),
    .elapsed (elapsed)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int ipow(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int clamp_div(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  int                    m_phase;
  int                    m_bcount;
  int                    m_period;
  int                    m_pend;
  bit                    m_pend_v;
  logic [NUM_STAGES-1:0] exp_tick;
  logic [ELAPSED_W-1:0]  exp_el;

  always @(posedge clk or negedge rst_n) begin : model_b
    int                    ph;
    int                    bc;
    int                    per;
    int                    pd;
    bit                    pv;
    bit                    wrap;
    logic [NUM_STAGES-1:0] t;
    if (!rst_n) begin
      m_phase  <= 0;
      m_bcount <= 0;
      m_period <= BASE_DIV;
      m_pend   <= 0;
      m_pend_v <= 1'b0;
      exp_tick <= '0;
      exp_el   <= '0;
    end else begin
      ph   = m_phase;
      bc   = m_bcount;
      per  = m_period;
      pd   = m_pend;
      pv   = m_pend_v;
      t    = '0;
      wrap = en && (ph == per - 1);
      if (clr) begin
        ph = 0;
        bc = 0;
      end else if (en) begin
        if (wrap) begin
          ph = 0;
          bc = bc + 1;
          for (int k = 0; k < NUM_STAGES; k++)
            if (bc % ipow(STAGE_DIV, k) == 0) t[k] = 1'b1;
        end else begin
          ph = ph + 1;
        end
      end
      if (div_wr) begin
        if (clr || wrap) begin
          per = clamp_div(int'(div_val));
          pv  = 1'b0;
        end else begin
          pd = clamp_div(int'(div_val));
          pv = 1'b1;
        end
      end else if ((clr || wrap) && pv) begin
        per = pd;
        pv  = 1'b0;
      end
      m_phase  <= ph;
      m_bcount <= bc;
      m_period <= per;
      m_pend   <= pd;
      m_pend_v <= pv;
      exp_tick <= t;
      exp_el   <= ELAPSED_W'((bc > EL_MAX) ? EL_MAX : bc);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard helpers and per-cycle compare process
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("tick_vs_model", 32'(tick), 32'(exp_tick));
      check("elapsed_vs_model", 32'(elapsed), 32'(exp_el));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input logic e, input logic c, input logic w, input logic [CW-1:0] v);
    en      = e;
    clr     = c;
    div_wr  = w;
    div_val = v;
    @(posedge clk);
    #1;
    clr    = 1'b0;
    div_wr = 1'b0;
  endtask

  // Run enabled cycles until tick[0] is seen; n = number of clock edges taken.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step(1'b1, 1'b0, 1'b0, '0);
      n++;
    end while (!tick[0] && n < 50);
    if (!tick[0]) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_tick: no tick[0] within 50 cycles at %0t", $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] got0[$];
    logic [7:0] got1[$];
    logic [7:0] got2[$];
    int         n;

    rst_n = 1'b1; en = 1'b1; clr = 1'b0; div_wr = 1'b0; div_val = '0;
    #2  rst_n = 1'b0;
    #21 rst_n = 1'b1;      // released between edges; next edge closes cycle 0
    chk_en = 1'b1;

    // 1. Free run: record the cycles in which each tick is high.
    for (int cyc = 1; cyc <= 46; cyc++) begin
      @(posedge clk);
      #1;
      if (tick[0]) got0.push_back(8'(cyc));
      if (tick[1]) got1.push_back(8'(cyc));
      if (tick[2]) got2.push_back(8'(cyc));
    end
    exp_q = {};
    for (int i = 1; i <= 9; i++) exp_q.push_back(8'(5 * i));
    check("tick0_count", got0.size(), exp_q.size());
    foreach (got0[i]) if (i < exp_q.size()) check("tick0_cycle", 32'(got0[i]), 32'(exp_q[i]));
    exp_q = {8'd15, 8'd30, 8'd45};
    check("tick1_count", got1.size(), exp_q.size());
    foreach (got1[i]) if (i < exp_q.size()) check("tick1_cycle", 32'(got1[i]), 32'(exp_q[i]));
    exp_q = {8'd45};
    check("tick2_count", got2.size(), exp_q.size());
    foreach (got2[i]) if (i < exp_q.size()) check("tick2_cycle", 32'(got2[i]), 32'(exp_q[i]));
    check("elapsed_after_9", 32'(elapsed), 32'd9);

    // 2. Freeze at c0=2 for 7 cycles; resume needs 3 more enabled cycles.
    step(1'b1, 1'b1, 1'b0, '0);
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    repeat (7) step(1'b0, 1'b0, 1'b0, '0);
    wait_tick(n);
    check("resume_latency", n, 3);

    // 3. clr coincident with the base wrap (c0=4).
    repeat (4) step(1'b1, 1'b0, 1'b0, '0);
    check("pre_clr_elapsed", 32'(elapsed), 32'd1);
    step(1'b1, 1'b1, 1'b0, '0);
    check("clr_wrap_tick", 32'(tick), 32'd0);
    check("clr_wrap_elapsed", 32'(elapsed), 32'd0);
    wait_tick(n);
    check("post_clr_latency", n, 5);

    // 4. Saturation of elapsed.
    step(1'b1, 1'b1, 1'b0, '0);
    repeat (40) step(1'b1, 1'b0, 1'b0, '0);
    check("elapsed_8", 32'(elapsed), 32'd8);
    repeat (62) step(1'b1, 1'b0, 1'b0, '0);
    check("elapsed_sat", 32'(elapsed), 32'd15);

    // 5. Asynchronous reset mid-cycle while tick[0] is high.
    wait_tick(n);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tick", 32'(tick), 32'd0);
    check("async_rst_elapsed", 32'(elapsed), 32'd0);
    #2 rst_n = 1'b1;
    wait_tick(n);
    check("post_rst_latency", n, 5);

`ifdef TICKGEN_RUNTIME_DIV_EN
    // 6. Runtime divisor: current period finishes at 5, then period 3, then 2.
    step(1'b1, 1'b1, 1'b0, '0);
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, CW'(3));
    wait_tick(n);
    check("div3_finish_old", n, 2);
    wait_tick(n);
    check("div3_period_a", n, 3);
    wait_tick(n);
    check("div3_period_b", n, 3);
    step(1'b1, 1'b0, 1'b1, CW'(0));
    wait_tick(n);
    check("div0_finish_old", n, 2);
    wait_tick(n);
    check("div0_period_a", n, 2);
    wait_tick(n);
    check("div0_period_b", n, 2);
`endif

    // Random phase: checked every cycle by the compare process.
    for (int i = 0; i < 600; i++) begin
      logic          e;
      logic          c;
      logic          w;
      logic [CW-1:0] v;
      e = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 39) == 0);
      w = 1'b0;
      v = CW'($urandom_range(0, 7));
`ifdef TICKGEN_RUNTIME_DIV_EN
      w = ($urandom_range(0, 29) == 0);
`endif
      step(e, c, w, v);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
